btn_replay: RTL and testbench



---
 rtl/btn_replay_pkg.sv | 27 ++
 rtl/btn_replay_mem.sv | 27 ++
 rtl/btn_replay.sv | 228 ++++++++++++++++++++++
 tb/tb_btn_replay.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_replay_pkg.sv
// Shared definitions for the button record/replay block.
// Holds state encoding, button bit positions and run-entry packing.
package btn_replay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_PLAY = 2'd2
    } state_e;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_JUMP  = 2;

    localparam int DEF_DEPTH  = 64;
    localparam int DEF_ADDR_W = 6;
    localparam int DEF_RUN_W  = 8;
    localparam int DEF_BTN_W  = 3;

    // A stored entry is packed as {btn, run}, btn in the upper bits.
    function automatic int entry_w(input int btn_w, input int run_w);
        return btn_w + run_w;
    endfunction

    localparam int DEF_ENTRY_W = DEF_BTN_W + DEF_RUN_W;

endpackage

// File: rtl/btn_replay_mem.sv
// Run-entry buffer: DEPTH x DATA_W registers, sync write, async read.
// Ports: i_clk, i_we/i_waddr/i_wdata write port, i_raddr/o_rdata read.
module btn_replay_mem #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 11
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset; entry_cnt qualifies them.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/btn_replay.sv
// Record-and-replay source for the {jump,right,left} character buttons.
// Ports: rec_start/play_start/stop commands, btn_in live buttons,
// btn_out to character, state, entry_cnt, sticky overflow, play_done.
module btn_replay
    import btn_replay_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RUN_W  = DEF_RUN_W,
    parameter int BTN_W  = DEF_BTN_W
) (
    input  logic             debug_char_clk,
    input  logic             sys_rst_n,
    input  logic             rec_start,
    input  logic             play_start,
    input  logic             stop,
    input  logic [BTN_W-1:0] btn_in,
    output logic [BTN_W-1:0] btn_out,
    output logic [1:0]       state,
    output logic [ADDR_W:0]  entry_cnt,
    output logic             overflow,
    output logic             play_done
);

    localparam int ENTRY_W = entry_w(BTN_W, RUN_W);
    localparam logic [RUN_W-1:0] RUN_MAX = '1;
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_e r_state;
    state_e w_state_nxt;

    logic [BTN_W-1:0]   r_btn_out;
    logic [BTN_W-1:0]   w_btn_out_nxt;
    logic [BTN_W-1:0]   r_cur;
    logic [BTN_W-1:0]   w_cur_nxt;
    logic [RUN_W-1:0]   r_run;
    logic [RUN_W-1:0]   w_run_nxt;
    logic [RUN_W-1:0]   r_rem;
    logic [RUN_W-1:0]   w_rem_nxt;
    logic [ADDR_W:0]    r_cnt;
    logic [ADDR_W:0]    w_cnt_nxt;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W-1:0]  w_rd_ptr_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic               r_done;
    logic               w_done_nxt;

    logic               w_we;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [ENTRY_W-1:0] w_wr_data;
    logic [ENTRY_W-1:0] w_rd_data;
    logic [BTN_W-1:0]   w_rd_btn;
    logic [RUN_W-1:0]   w_rd_run;

    logic w_rec;
    logic w_play;
    logic w_full;
    logic w_extend;
    logic w_rem_more;
    logic w_has_next;

    // stop outranks rec_start, which outranks play_start.
    assign w_rec  = ~stop & rec_start;
    assign w_play = ~stop & ~rec_start & play_start;

    assign w_full     = (r_cnt == CNT_FULL);
    assign w_extend   = (btn_in == r_cur) && (r_run != RUN_MAX);
    assign w_rem_more = (r_rem > RUN_ONE);
    assign w_has_next = (({1'b0, r_rd_ptr} + CNT_ONE) < r_cnt);

    // One read port: entry 0 when starting playback from IDLE,
    // otherwise the entry after the one being played.
    assign w_rd_addr = (r_state == ST_PLAY) ?
                       r_rd_ptr + ADDR_W'(1) : '0;

    assign w_wr_data = {r_cur, r_run};
    assign w_rd_btn  = w_rd_data[ENTRY_W-1 -: BTN_W];
    assign w_rd_run  = w_rd_data[RUN_W-1:0];

    btn_replay_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (ENTRY_W)
    ) u_mem (
        .i_clk   (debug_char_clk),
        .i_we    (w_we),
        .i_waddr (r_cnt[ADDR_W-1:0]),
        .i_wdata (w_wr_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge debug_char_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_rec) begin
                    w_state_nxt = ST_REC;
                end else if (w_play && (r_cnt != '0)) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_REC: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_extend && w_full) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_rem_more && !w_has_next) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_btn_out_nxt = r_btn_out;
        w_cur_nxt     = r_cur;
        w_run_nxt     = r_run;
        w_rem_nxt     = r_rem;
        w_cnt_nxt     = r_cnt;
        w_rd_ptr_nxt  = r_rd_ptr;
        w_ovf_nxt     = r_ovf;
        w_done_nxt    = 1'b0;
        w_we          = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_btn_out_nxt = btn_in;
                if (w_rec) begin
                    w_cnt_nxt = '0;
                    w_ovf_nxt = 1'b0;
                    w_cur_nxt = btn_in;
                    w_run_nxt = RUN_ONE;
                end else if (w_play) begin
                    if (r_cnt != '0) begin
                        w_rd_ptr_nxt  = '0;
                        w_btn_out_nxt = w_rd_btn;
                        w_rem_nxt     = w_rd_run;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_REC: begin
                w_btn_out_nxt = btn_in;
                if (stop) begin
                    // Flush the pending run; btn_in is not recorded.
                    if (!w_full) begin
                        w_we      = 1'b1;
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end else begin
                        w_ovf_nxt = 1'b1;
                    end
                end else if (w_extend) begin
                    w_run_nxt = r_run + RUN_ONE;
                end else if (!w_full) begin
                    // Value change or saturated run closes the entry.
                    w_we      = 1'b1;
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    w_cur_nxt = btn_in;
                    w_run_nxt = RUN_ONE;
                end else begin
                    w_ovf_nxt = 1'b1;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    w_btn_out_nxt = '0;
                end else if (w_rem_more) begin
                    w_rem_nxt = r_rem - RUN_ONE;
                end else if (w_has_next) begin
                    w_rd_ptr_nxt  = r_rd_ptr + ADDR_W'(1);
                    w_btn_out_nxt = w_rd_btn;
                    w_rem_nxt     = w_rd_run;
                end else begin
                    w_btn_out_nxt = '0;
                    w_done_nxt    = 1'b1;
                end
            end
            default: w_btn_out_nxt = '0;
        endcase
    end

    always_ff @(posedge debug_char_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_btn_out <= '0;
            r_cur     <= '0;
            r_run     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_rd_ptr  <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_btn_out <= w_btn_out_nxt;
            r_cur     <= w_cur_nxt;
            r_run     <= w_run_nxt;
            r_rem     <= w_rem_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_ovf     <= w_ovf_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign btn_out   = r_btn_out;
    assign state     = r_state;
    assign entry_cnt = r_cnt;
    assign overflow  = r_ovf;
    assign play_done = r_done;

endmodule

// File: tb/tb_btn_replay.sv
// Bench for btn_replay: DEPTH=64 and DEPTH=4 instances share stimulus.
// A run-list reference model feeds a per-instance scoreboard.
module tb_btn_replay;

    typedef struct packed {
        logic [2:0] btn;
        logic [1:0] st;
        logic [6:0] cnt;
        logic       ovf;
        logic       done;
    } exp_t;

    typedef struct {
        logic [2:0] btn;
        int         run;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rec = 1'b0;
    logic       play = 1'b0;
    logic       stp = 1'b0;
    logic [2:0] bin = 3'b000;

    logic [2:0] bo0, bo1;
    logic [1:0] st0, st1;
    logic [6:0] cnt0;
    logic [2:0] cnt1;
    logic       ov0, ov1, pd0, pd1;

    always #5 clk = ~clk;

    btn_replay dut0 (
        .debug_char_clk (clk),
        .sys_rst_n      (rst_n),
        .rec_start      (rec),
        .play_start     (play),
        .stop           (stp),
        .btn_in         (bin),
        .btn_out        (bo0),
        .state          (st0),
        .entry_cnt      (cnt0),
        .overflow       (ov0),
        .play_done      (pd0)
    );

    btn_replay #(.DEPTH(4), .ADDR_W(2)) dut1 (
        .debug_char_clk (clk),
        .sys_rst_n      (rst_n),
        .rec_start      (rec),
        .play_start     (play),
        .stop           (stp),
        .btn_in         (bin),
        .btn_out        (bo1),
        .state          (st1),
        .entry_cnt      (cnt1),
        .overflow       (ov1),
        .play_done      (pd1)
    );

    int errors = 0;
    int checks = 0;

    int         dep [2] = '{64, 4};
    int         ms  [2];
    exp_t       cur [2];
    exp_t       sb  [2][$];
    ent_t       runs[2][$];
    ent_t       ents[2][$];
    logic [2:0] pq  [2][$];

    function automatic exp_t actual(input int i);
        exp_t a;
        if (i == 0) a = {bo0, st0, cnt0, ov0, pd0};
        else        a = {bo1, st1, {4'b0, cnt1}, ov1, pd1};
        return a;
    endfunction

    // Monitor: every tick the DUT presents outputs; compare to queue.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        for (int i = 0; i < 2; i++) begin
            if (sb[i].size() > 0) begin
                e = sb[i].pop_front();
                a = actual(i);
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL dut%0d_outputs t=%0t got btn=%b st=%0d cnt=%0d ovf=%b done=%b required btn=%b st=%0d cnt=%0d ovf=%b done=%b",
                             i, $time, a.btn, a.st, a.cnt, a.ovf, a.done,
                             e.btn, e.st, e.cnt, e.ovf, e.done);
                end
            end
        end
    end

    // Store recorded runs: keep at most dep entries, flag the rest.
    task automatic commit(input int i, inout exp_t e);
        int n;
        n = runs[i].size();
        ents[i].delete();
        for (int k = 0; k < n && k < dep[i]; k++) begin
            ents[i].push_back(runs[i][k]);
        end
        e.cnt = 7'(ents[i].size());
        if (n > dep[i]) e.ovf = 1'b1;
        ms[i] = 0;
    endtask

    task automatic mstep(input int i);
        exp_t e;
        ent_t t;
        int   n;
        e = cur[i];
        e.done = 1'b0;
        case (ms[i])
            0: begin
                e.btn = bin;
                if (!stp && rec) begin
                    ms[i] = 1;
                    runs[i].delete();
                    t.btn = bin;
                    t.run = 1;
                    runs[i].push_back(t);
                    e.cnt = 0;
                    e.ovf = 1'b0;
                end else if (!stp && play) begin
                    if (ents[i].size() > 0) begin
                        pq[i].delete();
                        foreach (ents[i][k]) begin
                            for (int r = 0; r < ents[i][k].run; r++)
                                pq[i].push_back(ents[i][k].btn);
                        end
                        e.btn = pq[i].pop_front();
                        ms[i] = 2;
                    end else begin
                        e.done = 1'b1;
                    end
                end
            end
            1: begin
                e.btn = bin;
                if (stp) begin
                    commit(i, e);
                end else begin
                    n = runs[i].size();
                    t = runs[i][n-1];
                    if (t.btn == bin && t.run < 255) begin
                        t.run++;
                        runs[i][n-1] = t;
                    end else begin
                        t.btn = bin;
                        t.run = 1;
                        runs[i].push_back(t);
                    end
                    if (runs[i].size() - 1 > dep[i]) begin
                        void'(runs[i].pop_back());
                        void'(runs[i].pop_back());
                        commit(i, e);
                        e.ovf = 1'b1;
                    end else begin
                        e.cnt = 7'(runs[i].size() - 1);
                    end
                end
            end
            default: begin
                if (stp) begin
                    e.btn = 3'b000;
                    ms[i] = 0;
                end else if (pq[i].size() > 0) begin
                    e.btn = pq[i].pop_front();
                end else begin
                    e.btn = 3'b000;
                    e.done = 1'b1;
                    ms[i] = 0;
                end
            end
        endcase
        e.st = 2'(ms[i]);
        cur[i] = e;
        sb[i].push_back(e);
    endtask

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            ms[i] = 0;
            cur[i] = '0;
            sb[i].delete();
            runs[i].delete();
            ents[i].delete();
            pq[i].delete();
        end
    endtask

    task automatic tick(input logic r, input logic p,
                        input logic s, input logic [2:0] b);
        rec = r;
        play = p;
        stp = s;
        bin = b;
        @(posedge clk);
        #1;
        mstep(0);
        mstep(1);
    endtask

    task automatic chk_reset(input string tag);
        exp_t a;
        for (int i = 0; i < 2; i++) begin
            a = actual(i);
            checks++;
            if (a !== '0) begin
                errors++;
                $display("FAIL %s dut%0d got btn=%b st=%0d cnt=%0d ovf=%b done=%b required all zero",
                         tag, i, a.btn, a.st, a.cnt, a.ovf, a.done);
            end
        end
    endtask

    task automatic reset_mid(input string tag);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset(tag);
        mreset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] b;
        mreset();
        #1 rst_n = 1'b0;
        #2 chk_reset("reset_values");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Empty playback: single play_done pulse, stays IDLE.
        tick(0, 1, 0, 3'b011);
        tick(0, 0, 0, 3'b000);
        tick(0, 0, 0, 3'b000);

        // Basic runs {001,5},{000,3}.
        tick(1, 0, 0, 3'b001);
        repeat (4) tick(0, 0, 0, 3'b001);
        repeat (3) tick(0, 0, 0, 3'b000);
        tick(0, 0, 1, 3'b000);
        tick(0, 0, 0, 3'b000);

        // Playback with live buttons all pressed.
        tick(0, 1, 0, 3'b111);
        repeat (10) tick(0, 0, 0, 3'b111);

        // Stop two ticks into playback, then replay in full.
        tick(0, 1, 0, 3'b000);
        tick(0, 0, 0, 3'b000);
        tick(0, 0, 1, 3'b000);
        tick(0, 0, 0, 3'b000);
        tick(0, 1, 1, 3'b000);
        tick(0, 1, 0, 3'b010);
        repeat (10) tick(0, 0, 0, 3'b010);

        // Saturation: jump held 300 ticks.
        tick(1, 0, 0, 3'b100);
        repeat (299) tick(0, 0, 0, 3'b100);
        tick(0, 0, 1, 3'b100);
        tick(0, 1, 0, 3'b000);
        repeat (302) tick(0, 0, 0, 3'b101);

        // Overflow: toggle every tick past both depths.
        tick(1, 0, 0, 3'b001);
        for (int k = 1; k < 72; k++)
            tick(0, 0, 0, (k % 2 == 1) ? 3'b010 : 3'b001);
        tick(0, 0, 1, 3'b000);
        tick(0, 1, 0, 3'b000);
        repeat (70) tick(0, 0, 0, 3'b000);
        tick(1, 0, 0, 3'b110);
        repeat (2) tick(0, 0, 0, 3'b110);
        tick(0, 0, 1, 3'b000);

        // Reset in the middle of playback.
        tick(0, 1, 0, 3'b000);
        repeat (2) tick(0, 0, 0, 3'b111);
        reset_mid("reset_mid_play");
        tick(0, 1, 0, 3'b000);

        // Randomized command and button stream.
        b = 3'b000;
        for (int n = 0; n < 5000; n++) begin
            if ($urandom_range(3) == 0) b = 3'($urandom_range(7));
            tick($urandom_range(29) == 0,
                 $urandom_range(24) == 0,
                 $urandom_range(69) == 0,
                 b);
        end

        tick(0, 0, 0, 3'b000);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
